// File: rtl/icache_pkg.sv
// Shared types and constants for the N-way instruction cache controller.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int REPL_LRU  = 0;
  localparam int REPL_LFSR = 1;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets);
    return 30 - $clog2(sets);
  endfunction

  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/icache_nway_ctrl_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
interface icache_nway_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 20
);
  logic              cpu_req;
  logic [31:0]       PC;
  logic              cpu_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] Data_Cache;
  logic              HitWrite;
  logic              mm_req;
  logic [31:0]       mm_addr;
  logic              mm_ack;
  logic [DATA_W-1:0] mm_data;
  logic              flush;
  logic [CNT_W-1:0]  CNT_HIT;
  logic [CNT_W-1:0]  CNT_MISS;

  modport slave (
    input  cpu_req, PC, mm_ack, mm_data, flush,
    output cpu_ready, rd_valid, Data_Cache, HitWrite, mm_req, mm_addr,
           CNT_HIT, CNT_MISS
  );

  modport master (
    output cpu_req, PC, mm_ack, mm_data, flush,
    input  cpu_ready, rd_valid, Data_Cache, HitWrite, mm_req, mm_addr,
           CNT_HIT, CNT_MISS
  );
endinterface

// File: rtl/icache_repl.sv
// Replacement state: per-set LRU ages and a free-running LFSR; picks the victim way.
module icache_repl
  import icache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 4,
  parameter int REPL = 0
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [idx_w(SETS)-1:0]   set_idx,
  input  logic [WAYS-1:0]          valid_vec,
  input  logic                     upd,
  input  logic [way_w(WAYS)-1:0]   upd_way,
  input  logic                     clr,
  output logic [way_w(WAYS)-1:0]   victim
);
  localparam int WAY_W = way_w(WAYS);

  logic [WAY_W-1:0] age_q [SETS][WAYS];
  logic [WAY_W-1:0] age_d [SETS][WAYS];
  logic [15:0]      lfsr_q;
  logic [15:0]      lfsr_d;
  logic             found;
  logic [WAY_W-1:0] max_age;

  assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};

  always_comb begin
    age_d = age_q;
    if (clr) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_d[s][w] = WAY_W'(w);
    end else if (upd) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == upd_way)
          age_d[set_idx][w] = '0;
        else if (age_q[set_idx][w] < age_q[set_idx][upd_way])
          age_d[set_idx][w] = age_q[set_idx][w] + 1'b1;
      end
    end
  end

  // Invalid ways are always filled first; policy only matters for a full set.
  always_comb begin
    found   = 1'b0;
    victim  = '0;
    max_age = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_vec[w]) begin
        found  = 1'b1;
        victim = WAY_W'(w);
      end
    end
    if (!found) begin
      if (REPL == REPL_LFSR) begin
        victim = (WAYS == 1) ? '0 : lfsr_q[WAY_W-1:0];
      end else begin
        for (int w = 0; w < WAYS; w++) begin
          if (age_q[set_idx][w] > max_age) begin
            max_age = age_q[set_idx][w];
            victim  = WAY_W'(w);
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lfsr_q <= LFSR_SEED;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
    end else begin
      lfsr_q <= lfsr_d;
      age_q  <= age_d;
    end
  end

endmodule

// File: rtl/icache_nway_ctrl.sv
// N-way set-associative instruction cache with miss handshake, flush and hit/miss counters.
module icache_nway_ctrl
  import icache_pkg::*;
#(
  parameter int WAYS   = 2,
  parameter int SETS   = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 20,
  parameter int REPL   = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  icache_nway_ctrl_if.slave bus
);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(SETS);
  localparam int WAY_W = way_w(WAYS);

  logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
  logic [DATA_W-1:0] data_mem [SETS][WAYS];
  logic [WAYS-1:0]   valid_q  [SETS];
  logic [WAYS-1:0]   valid_d  [SETS];

  state_e            state_q, state_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              hitwrite_q, hitwrite_d;
  logic              mm_req_q, mm_req_d;
  logic [31:0]       mm_addr_q, mm_addr_d;
  logic [CNT_W-1:0]  cnt_hit_q, cnt_hit_d;
  logic [CNT_W-1:0]  cnt_miss_q, cnt_miss_d;

  logic [IDX_W-1:0]  pc_idx, miss_idx, repl_idx;
  logic [TAG_W-1:0]  pc_tag, miss_tag;
  logic              cpu_ready, accept, fill, flush_go;
  logic              hit;
  logic [WAY_W-1:0]  hit_way, victim, upd_way;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign pc_idx   = bus.PC[IDX_W+1:2];
  assign pc_tag   = bus.PC[31:IDX_W+2];
  assign miss_idx = mm_addr_q[IDX_W+1:2];
  assign miss_tag = mm_addr_q[31:IDX_W+2];

  // Flush takes priority over a same-cycle fetch request.
  assign cpu_ready = (state_q == IDLE) && !bus.flush;
  assign accept    = bus.cpu_req && cpu_ready;
  assign flush_go  = (state_q == IDLE) && bus.flush;
  assign fill      = (state_q == MISS) && bus.mm_ack;
  assign repl_idx  = (state_q == MISS) ? miss_idx : pc_idx;
  assign upd_way   = fill ? victim : hit_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[pc_idx][w] && (tag_mem[pc_idx][w] == pc_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  icache_repl #(
    .WAYS (WAYS),
    .SETS (SETS),
    .REPL (REPL)
  ) u_repl (
    .CLK       (CLK),
    .RESET     (RESET),
    .set_idx   (repl_idx),
    .valid_vec (valid_q[repl_idx]),
    .upd       ((accept && hit) || fill),
    .upd_way   (upd_way),
    .clr       (flush_go),
    .victim    (victim)
  );

  always_comb begin
    state_d    = state_q;
    rd_valid_d = 1'b0;
    data_out_d = data_out_q;
    hitwrite_d = hitwrite_q;
    mm_req_d   = mm_req_q;
    mm_addr_d  = mm_addr_q;
    cnt_hit_d  = cnt_hit_q;
    cnt_miss_d = cnt_miss_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: begin
        if (flush_go) begin
          for (int s = 0; s < SETS; s++) valid_d[s] = '0;
        end else if (accept) begin
          if (hit) begin
            rd_valid_d = 1'b1;
            data_out_d = data_mem[pc_idx][hit_way];
            hitwrite_d = 1'b1;
            cnt_hit_d  = sat_inc(cnt_hit_q);
          end else begin
            state_d    = MISS;
            mm_req_d   = 1'b1;
            mm_addr_d  = {bus.PC[31:2], 2'b00};
            hitwrite_d = 1'b0;
            cnt_miss_d = sat_inc(cnt_miss_q);
          end
        end
      end
      MISS: begin
        if (bus.mm_ack) begin
          valid_d[miss_idx][victim] = 1'b1;
          state_d    = RESP;
          mm_req_d   = 1'b0;
          rd_valid_d = 1'b1;
          data_out_d = bus.mm_data;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      rd_valid_q <= 1'b0;
      data_out_q <= '0;
      hitwrite_q <= 1'b1;
      mm_req_q   <= 1'b0;
      mm_addr_q  <= '0;
      cnt_hit_q  <= '0;
      cnt_miss_q <= '0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      data_out_q <= data_out_d;
      hitwrite_q <= hitwrite_d;
      mm_req_q   <= mm_req_d;
      mm_addr_q  <= mm_addr_d;
      cnt_hit_q  <= cnt_hit_d;
      cnt_miss_q <= cnt_miss_d;
      valid_q    <= valid_d;
    end
  end

  // Line payload is only meaningful behind a valid bit, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_mem[miss_idx][victim]  <= miss_tag;
      data_mem[miss_idx][victim] <= bus.mm_data;
    end
  end

  assign bus.cpu_ready  = cpu_ready;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.Data_Cache = data_out_q;
  assign bus.HitWrite   = hitwrite_q;
  assign bus.mm_req     = mm_req_q;
  assign bus.mm_addr    = mm_addr_q;
  assign bus.CNT_HIT    = cnt_hit_q;
  assign bus.CNT_MISS   = cnt_miss_q;

endmodule

// File: tb/tb_icache_nway_ctrl.sv
// Directed bench: cache A is 2-way LRU, cache B is 4-way LFSR with 4-bit counters.
module tb_icache_nway_ctrl;
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  icache_nway_ctrl_if #(.DATA_W(32), .CNT_W(20)) ia ();
  icache_nway_ctrl_if #(.DATA_W(32), .CNT_W(4))  ib ();

  icache_nway_ctrl #(.WAYS(2), .SETS(4), .DATA_W(32), .CNT_W(20), .REPL(0)) dut_a (
    .CLK(CLK), .RESET(RESET), .bus(ia.slave));
  icache_nway_ctrl #(.WAYS(4), .SETS(4), .DATA_W(32), .CNT_W(4), .REPL(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .bus(ib.slave));

  logic        cpu_req [2];
  logic [31:0] pc      [2];
  logic        mm_ack  [2];
  logic [31:0] mm_data [2];
  logic        flush   [2];
  logic        ready   [2];
  logic        rdv     [2];
  logic        hw      [2];
  logic        mreq    [2];
  logic [31:0] data    [2];
  logic [31:0] maddr   [2];
  logic [19:0] chit    [2];
  logic [19:0] cmiss   [2];

  assign ia.cpu_req = cpu_req[0];
  assign ia.PC      = pc[0];
  assign ia.mm_ack  = mm_ack[0];
  assign ia.mm_data = mm_data[0];
  assign ia.flush   = flush[0];
  assign ib.cpu_req = cpu_req[1];
  assign ib.PC      = pc[1];
  assign ib.mm_ack  = mm_ack[1];
  assign ib.mm_data = mm_data[1];
  assign ib.flush   = flush[1];

  assign ready[0] = ia.cpu_ready;  assign ready[1] = ib.cpu_ready;
  assign rdv[0]   = ia.rd_valid;   assign rdv[1]   = ib.rd_valid;
  assign hw[0]    = ia.HitWrite;   assign hw[1]    = ib.HitWrite;
  assign mreq[0]  = ia.mm_req;     assign mreq[1]  = ib.mm_req;
  assign data[0]  = ia.Data_Cache; assign data[1]  = ib.Data_Cache;
  assign maddr[0] = ia.mm_addr;    assign maddr[1] = ib.mm_addr;
  assign chit[0]  = ia.CNT_HIT;    assign chit[1]  = 20'(ib.CNT_HIT);
  assign cmiss[0] = ia.CNT_MISS;   assign cmiss[1] = 20'(ib.CNT_MISS);

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cpu_req[d] = 1'b0; pc[d] = '0; mm_ack[d] = 1'b0; mm_data[d] = '0; flush[d] = 1'b0;
    end
    step();
    step();
    RESET = 1'b0;
  endtask

  // One complete fetch; a miss is served immediately with the given fill word.
  task automatic fetch(input int d, input logic [31:0] a, input logic [31:0] fill,
                       output logic hit, output logic [31:0] got);
    int n;
    n   = 0;
    hit = 1'b0;
    got = '0;
    while (!ready[d] && n < 50) begin
      step();
      n++;
    end
    check("ready_before_req", 32'(ready[d]), 32'd1);
    cpu_req[d] = 1'b1;
    pc[d]      = a;
    step();
    cpu_req[d] = 1'b0;
    check("req_response", 32'(rdv[d] | mreq[d]), 32'd1);
    if (rdv[d]) begin
      hit = 1'b1;
      got = data[d];
    end else if (mreq[d]) begin
      mm_ack[d]  = 1'b1;
      mm_data[d] = fill;
      step();
      mm_ack[d]  = 1'b0;
      got = data[d];
      check("fill_rd_valid", 32'(rdv[d]), 32'd1);
      step();
    end
  endtask

  logic        h;
  logic [31:0] g;
  logic [3:0]  pat   [2];
  logic [19:0] run_h [2];
  logic [19:0] run_m [2];

  initial begin
    do_reset();
    // Reset state
    check("rst_cpu_ready", 32'(ready[0]), 32'd1);
    check("rst_rd_valid",  32'(rdv[0]),   32'd0);
    check("rst_data",      data[0],       32'd0);
    check("rst_hitwrite",  32'(hw[0]),    32'd1);
    check("rst_mm_req",    32'(mreq[0]),  32'd0);
    check("rst_mm_addr",   maddr[0],      32'd0);
    check("rst_cnt_hit",   32'(chit[0]),  32'd0);
    check("rst_cnt_miss",  32'(cmiss[0]), 32'd0);

    // Cold miss on 0x10
    cpu_req[0] = 1'b1; pc[0] = 32'h10;
    step();
    cpu_req[0] = 1'b0;
    check("cold_mm_req",    32'(mreq[0]),  32'd1);
    check("cold_mm_addr",   maddr[0],      32'h10);
    check("cold_hitwrite",  32'(hw[0]),    32'd0);
    check("cold_cpu_ready", 32'(ready[0]), 32'd0);
    check("cold_cnt_miss",  32'(cmiss[0]), 32'd1);
    step();
    check("miss_wait_mm_req", 32'(mreq[0]), 32'd1);
    check("miss_wait_rdv",    32'(rdv[0]),  32'd0);
    mm_ack[0] = 1'b1; mm_data[0] = 32'hDEADBEEF;
    step();
    mm_ack[0] = 1'b0;
    check("resp_rd_valid",  32'(rdv[0]),   32'd1);
    check("resp_data",      data[0],       32'hDEADBEEF);
    check("resp_mm_req",    32'(mreq[0]),  32'd0);
    check("resp_cpu_ready", 32'(ready[0]), 32'd0);
    step();
    check("idle_rd_valid",  32'(rdv[0]),   32'd0);
    check("idle_cpu_ready", 32'(ready[0]), 32'd1);

    // Hit on 0x10
    cpu_req[0] = 1'b1; pc[0] = 32'h10;
    step();
    cpu_req[0] = 1'b0;
    check("hit_rd_valid", 32'(rdv[0]),  32'd1);
    check("hit_data",     data[0],      32'hDEADBEEF);
    check("hit_hitwrite", 32'(hw[0]),   32'd1);
    check("hit_cnt_hit",  32'(chit[0]), 32'd1);
    check("hit_mm_req",   32'(mreq[0]), 32'd0);

    // LRU eviction in set 0
    fetch(0, 32'h00, 32'h0000_1111, h, g);
    check("lru_fill00_hit", 32'(h), 32'd0);
    fetch(0, 32'h00, 32'h0, h, g);
    check("lru_hit00", 32'(h), 32'd1);
    check("lru_hit00_data", g, 32'h0000_1111);
    fetch(0, 32'h20, 32'h0000_2222, h, g);
    check("lru_miss20", 32'(h), 32'd0);
    check("lru_miss20_addr", maddr[0], 32'h20);
    fetch(0, 32'h00, 32'h0, h, g);
    check("lru_00_kept", 32'(h), 32'd1);
    fetch(0, 32'h10, 32'h0000_3333, h, g);
    check("lru_10_evicted", 32'(h), 32'd0);
    check("lru_cnt_hit",  32'(chit[0]),  32'd3);
    check("lru_cnt_miss", 32'(cmiss[0]), 32'd4);

    // Stray ack in IDLE
    mm_ack[0] = 1'b1; mm_data[0] = 32'hBAD0BAD0;
    step();
    mm_ack[0] = 1'b0;
    check("stray_ack_rdv",   32'(rdv[0]),   32'd0);
    check("stray_ack_ready", 32'(ready[0]), 32'd1);
    check("stray_ack_miss",  32'(cmiss[0]), 32'd4);

    // Flush
    fetch(0, 32'h04, 32'h0000_4444, h, g);
    fetch(0, 32'h04, 32'h0, h, g);
    check("flush_pre_hit", 32'(h), 32'd1);
    flush[0] = 1'b1; cpu_req[0] = 1'b1; pc[0] = 32'h04;
    #1;
    check("flush_cpu_ready", 32'(ready[0]), 32'd0);
    step();
    flush[0] = 1'b0; cpu_req[0] = 1'b0;
    check("flush_rdv",     32'(rdv[0]),   32'd0);
    check("flush_mm_req",  32'(mreq[0]),  32'd0);
    check("flush_cnt_hit", 32'(chit[0]),  32'd4);
    fetch(0, 32'h04, 32'h0000_5555, h, g);
    check("post_flush_miss", 32'(h), 32'd0);
    check("post_flush_cnt_miss", 32'(cmiss[0]), 32'd6);

    // Reset while a miss is outstanding
    cpu_req[0] = 1'b1; pc[0] = 32'h08;
    step();
    cpu_req[0] = 1'b0;
    check("midmiss_mm_req", 32'(mreq[0]), 32'd1);
    RESET = 1'b1;
    #1;
    check("rst_mid_mm_req",   32'(mreq[0]),  32'd0);
    check("rst_mid_ready",    32'(ready[0]), 32'd1);
    check("rst_mid_cnt_miss", 32'(cmiss[0]), 32'd0);
    step();
    RESET = 1'b0;
    mm_ack[0] = 1'b1; mm_data[0] = 32'h0BAD_F00D;
    step();
    mm_ack[0] = 1'b0;
    check("late_ack_rdv",   32'(rdv[0]),   32'd0);
    check("late_ack_ready", 32'(ready[0]), 32'd1);
    fetch(0, 32'h10, 32'h0000_6666, h, g);
    check("rst_lines_invalid", 32'(h), 32'd0);

    // LFSR replacement: identical sequence twice after reset
    for (int r = 0; r < 2; r++) begin
      do_reset();
      for (int i = 0; i < 5; i++)
        fetch(1, 32'(i * 16), 32'(32'hA000 + i), h, g);
      fetch(1, 32'h40, 32'h0, h, g);
      check("lfsr_new_line_hit", 32'(h), 32'd1);
      check("lfsr_new_line_data", g, 32'h0000_A004);
      for (int i = 0; i < 4; i++) begin
        fetch(1, 32'(i * 16), 32'(32'hB000 + i), h, g);
        pat[r][i] = h;
      end
      run_h[r] = chit[1];
      run_m[r] = cmiss[1];
      check("lfsr_one_evicted", 32'(pat[r] != 4'hF), 32'd1);
    end
    check("lfsr_same_pattern",  32'(pat[1]),  32'(pat[0]));
    check("lfsr_same_cnt_hit",  32'(run_h[1]), 32'(run_h[0]));
    check("lfsr_same_cnt_miss", 32'(run_m[1]), 32'(run_m[0]));

    // Counter saturation at 4 bits
    do_reset();
    fetch(1, 32'h0C, 32'h0000_C0DE, h, g);
    for (int i = 1; i <= 20; i++) begin
      fetch(1, 32'h0C, 32'h0, h, g);
      if (i == 15) check("sat_cnt_hit_15", 32'(chit[1]), 32'd15);
    end
    check("sat_cnt_hit_hold", 32'(chit[1]),  32'd15);
    check("sat_cnt_miss",     32'(cmiss[1]), 32'd1);
    check("sat_hit_data",     g,             32'h0000_C0DE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
